// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Contents: decoder bit positions, FSM state encodings and default widths.
package mem_stage_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W          = 8;

    localparam int DEC_REGWRITE = 4;
    localparam int DEC_MEMTOREG = 3;
    localparam int DEC_BRANCH   = 2;
    localparam int DEC_MEMREAD  = 1;
    localparam int DEC_MEMWRITE = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// Flat MEM/WB pipeline register. Asserting bubble_i loads an all-zero entry
// instead of the incoming fields.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  bubble_i,
    input  logic                  regwrite_i,
    input  logic                  memtoreg_i,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [DATA_W-1:0]     alu_i,
    input  logic [DATA_W-1:0]     pc4_i,
    input  logic [REG_ADDR_W-1:0] dst_i,
    output logic                  regwrite_o,
    output logic                  memtoreg_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [DATA_W-1:0]     alu_o,
    output logic [DATA_W-1:0]     pc4_o,
    output logic [REG_ADDR_W-1:0] dst_o
);

    logic                  regwrite_q, memtoreg_q;
    logic [DATA_W-1:0]     rdata_q, alu_q, pc4_q;
    logic [REG_ADDR_W-1:0] dst_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n || bubble_i) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rdata_q    <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            dst_q      <= '0;
        end else begin
            regwrite_q <= regwrite_i;
            memtoreg_q <= memtoreg_i;
            rdata_q    <= rdata_i;
            alu_q      <= alu_i;
            pc4_q      <= pc4_i;
            dst_q      <= dst_i;
        end
    end

    assign regwrite_o = regwrite_q;
    assign memtoreg_o = memtoreg_q;
    assign rdata_o    = rdata_q;
    assign alu_o      = alu_q;
    assign pc4_o      = pc4_q;
    assign dst_o      = dst_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ack handshake, pipeline stall, branch/jump redirect, MEM/WB register.
// Define MEM_TIMEOUT_EN to enable the WAIT-state watchdog (sticky timeout_o).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic [4:0]            decoder_i,
    input  logic [DATA_W-1:0]     PC_plus4_i,
    input  logic                  zero_i,
    input  logic [DATA_W-1:0]     FURslt_i,
    input  logic [DATA_W-1:0]     ReadData2_i,
    input  logic [REG_ADDR_W-1:0] instruction_i,
    input  logic [DATA_W-1:0]     jump_addr_i,
    input  logic                  jump_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_W-1:0]     dmem_addr_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  stall_o,
    output logic                  pc_src_o,
    output logic [DATA_W-1:0]     pc_target_o,
    output logic                  flush_o,
    output logic                  misalign_o,
    output logic                  timeout_o,
    output logic                  wb_regwrite_o,
    output logic                  wb_memtoreg_o,
    output logic [DATA_W-1:0]     wb_rdata_o,
    output logic [DATA_W-1:0]     wb_alu_o,
    output logic [DATA_W-1:0]     wb_pc4_o,
    output logic [REG_ADDR_W-1:0] wb_dst_o
);

    state_e            state_q, state_d;
    logic              mem_op, align_ok, go, read_only;
    logic              req_raw, timeout_hit;
    logic              misalign_q, misalign_d;
    logic              wb_bubble;
    logic [DATA_W-1:0] wb_rdata_in;

    assign mem_op    = decoder_i[DEC_MEMREAD] | decoder_i[DEC_MEMWRITE];
    assign align_ok  = (FURslt_i[1:0] == 2'b00);
    assign go        = mem_op & align_ok;
    assign read_only = decoder_i[DEC_MEMREAD] & ~decoder_i[DEC_MEMWRITE];

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC)) && !dmem_ack_i;

    always_comb begin
        cnt_d     = (state_q == ST_WAIT) ? cnt_q + 1'b1 : '0;
        timeout_d = timeout_q | timeout_hit;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_raw = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_raw = go;
                if (go && !dmem_ack_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                req_raw = !timeout_hit;
                if (dmem_ack_i || timeout_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    // Outputs are gated by rst_n so an in-flight request drops the moment reset asserts.
    assign dmem_req_o   = rst_n & req_raw;
    assign dmem_we_o    = rst_n & decoder_i[DEC_MEMWRITE];
    assign dmem_addr_o  = rst_n ? FURslt_i    : '0;
    assign dmem_wdata_o = rst_n ? ReadData2_i : '0;
    assign stall_o      = dmem_req_o & ~dmem_ack_i;

    assign pc_src_o    = rst_n & (jump_i | (decoder_i[DEC_BRANCH] & zero_i));
    assign pc_target_o = rst_n ? jump_addr_i : '0;
    assign flush_o     = pc_src_o;

    assign misalign_d  = (state_q == ST_IDLE) & mem_op & ~align_ok;
    assign misalign_o  = misalign_q;
    assign wb_bubble   = stall_o | misalign_d | timeout_hit;
    assign wb_rdata_in = (dmem_req_o && dmem_ack_i && read_only) ? dmem_rdata_i : '0;

    mem_wb_reg #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mem_wb_reg (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .bubble_i   (wb_bubble),
        .regwrite_i (decoder_i[DEC_REGWRITE]),
        .memtoreg_i (decoder_i[DEC_MEMTOREG]),
        .rdata_i    (wb_rdata_in),
        .alu_i      (FURslt_i),
        .pc4_i      (PC_plus4_i),
        .dst_i      (instruction_i),
        .regwrite_o (wb_regwrite_o),
        .memtoreg_o (wb_memtoreg_o),
        .rdata_o    (wb_rdata_o),
        .alu_o      (wb_alu_o),
        .pc4_o      (wb_pc4_o),
        .dst_o      (wb_dst_o)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: MEM/WB expectations are queued when a cycle is driven
// and compared after the clock edge that should capture them.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [4:0]  decoder_i;
    logic [31:0] PC_plus4_i, FURslt_i, ReadData2_i, jump_addr_i, dmem_rdata_i;
    logic [4:0]  instruction_i;
    logic        zero_i, jump_i, dmem_ack_i;
    logic        dmem_req_o, dmem_we_o, stall_o, pc_src_o, flush_o, misalign_o, timeout_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, pc_target_o;
    logic        wb_regwrite_o, wb_memtoreg_o;
    logic [31:0] wb_rdata_o, wb_alu_o, wb_pc4_o;
    logic [4:0]  wb_dst_o;

    int checkCount = 0;
    int errCount   = 0;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [4:0]  dst;
    } wb_t;

    wb_t sbQ[$];
    wb_t bubble;

    always #5 clk_i = ~clk_i;

    mem_stage #(
        .DATA_W      (32),
        .REG_ADDR_W  (5),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .decoder_i     (decoder_i),
        .PC_plus4_i    (PC_plus4_i),
        .zero_i        (zero_i),
        .FURslt_i      (FURslt_i),
        .ReadData2_i   (ReadData2_i),
        .instruction_i (instruction_i),
        .jump_addr_i   (jump_addr_i),
        .jump_i        (jump_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_ack_i    (dmem_ack_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_o       (stall_o),
        .pc_src_o      (pc_src_o),
        .pc_target_o   (pc_target_o),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o),
        .timeout_o     (timeout_o),
        .wb_regwrite_o (wb_regwrite_o),
        .wb_memtoreg_o (wb_memtoreg_o),
        .wb_rdata_o    (wb_rdata_o),
        .wb_alu_o      (wb_alu_o),
        .wb_pc4_o      (wb_pc4_o),
        .wb_dst_o      (wb_dst_o)
    );

    function automatic wb_t mkWb(input logic rw, input logic mtr, input logic [31:0] rdata,
                                 input logic [31:0] alu, input logic [31:0] pc4, input logic [4:0] dst);
        wb_t w;
        w.rw = rw; w.mtr = mtr; w.rdata = rdata; w.alu = alu; w.pc4 = pc4; w.dst = dst;
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] dec, input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [31:0] pc4, input logic [4:0] dst, input logic zero,
                                 input logic [31:0] jaddr, input logic jump, input logic ack,
                                 input logic [31:0] rdata);
        decoder_i = dec; FURslt_i = alu; ReadData2_i = wd; PC_plus4_i = pc4; instruction_i = dst;
        zero_i = zero; jump_addr_i = jaddr; jump_i = jump; dmem_ack_i = ack; dmem_rdata_i = rdata;
    endtask

    // Called just after a rising edge with inputs already driven; ends just after the next edge.
    task automatic stepCycle(input string tag, input logic expReq, input logic expStall,
                             input logic expMis, input wb_t expWb);
        wb_t got;
        sbQ.push_back(expWb);
        @(negedge clk_i);
        checkOutput({tag, ".req"}, 32'(dmem_req_o), 32'(expReq));
        checkOutput({tag, ".stall"}, 32'(stall_o), 32'(expStall));
        @(posedge clk_i);
        #1;
        checkOutput({tag, ".misalign"}, 32'(misalign_o), 32'(expMis));
        if (sbQ.size() == 0) begin
            checkOutput({tag, ".sbEmpty"}, 32'd1, 32'd0);
        end else begin
            got = sbQ.pop_front();
            checkOutput({tag, ".wbRegWrite"}, 32'(wb_regwrite_o), 32'(got.rw));
            checkOutput({tag, ".wbMemtoReg"}, 32'(wb_memtoreg_o), 32'(got.mtr));
            checkOutput({tag, ".wbRdata"}, wb_rdata_o, got.rdata);
            checkOutput({tag, ".wbAlu"}, wb_alu_o, got.alu);
            checkOutput({tag, ".wbPc4"}, wb_pc4_o, got.pc4);
            checkOutput({tag, ".wbDst"}, 32'(wb_dst_o), 32'(got.dst));
        end
    endtask

    initial begin
        bubble = mkWb(1'b0, 1'b0, '0, '0, '0, '0);
        rst_n  = 1'b0;
        applyStimulus(5'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
        #3;
        checkOutput("rst.req", 32'(dmem_req_o), 32'd0);
        checkOutput("rst.stall", 32'(stall_o), 32'd0);
        checkOutput("rst.timeout", 32'(timeout_o), 32'd0);
        checkOutput("rst.misalign", 32'(misalign_o), 32'd0);
        checkOutput("rst.wbRegWrite", 32'(wb_regwrite_o), 32'd0);
        checkOutput("rst.wbAlu", wb_alu_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;

        // Load at 0x10, three wait cycles, then ack with data.
        applyStimulus(5'b11010, 32'h10, 32'h0, 32'h104, 5'd7, 1'b0, '0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("ld.addr", dmem_addr_o, 32'h10);
        checkOutput("ld.we", 32'(dmem_we_o), 32'd0);
        for (int i = 0; i < 3; i++) stepCycle($sformatf("ldWait%0d", i), 1'b1, 1'b1, 1'b0, bubble);
        applyStimulus(5'b11010, 32'h10, 32'h0, 32'h104, 5'd7, 1'b0, '0, 1'b0, 1'b1, 32'hDEADBEEF);
        stepCycle("ldAck", 1'b1, 1'b0, 1'b0, mkWb(1'b1, 1'b1, 32'hDEADBEEF, 32'h10, 32'h104, 5'd7));

        // Zero-wait store; rdata on the bus must not reach MEM/WB.
        applyStimulus(5'b00001, 32'h20, 32'h1234, 32'h108, 5'd9, 1'b0, '0, 1'b0, 1'b1, 32'hAAAA5555);
        #1;
        checkOutput("st.we", 32'(dmem_we_o), 32'd1);
        checkOutput("st.addr", dmem_addr_o, 32'h20);
        checkOutput("st.wdata", dmem_wdata_o, 32'h1234);
        stepCycle("st", 1'b1, 1'b0, 1'b0, mkWb(1'b0, 1'b0, 32'h0, 32'h20, 32'h108, 5'd9));

        // Misaligned load: no request, bubble, one-cycle misalign pulse.
        applyStimulus(5'b11010, 32'h13, 32'h0, 32'h10C, 5'd5, 1'b0, '0, 1'b0, 1'b0, 32'h0);
        stepCycle("mis", 1'b0, 1'b0, 1'b1, bubble);
        applyStimulus(5'b10000, 32'h99, 32'h0, 32'h110, 5'd6, 1'b0, '0, 1'b0, 1'b0, 32'h0);
        stepCycle("aluOp", 1'b0, 1'b0, 1'b0, mkWb(1'b1, 1'b0, 32'h0, 32'h99, 32'h110, 5'd6));

        // Redirects.
        applyStimulus(5'b00100, 32'h5, 32'h0, 32'h114, 5'd0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("brT.pcSrc", 32'(pc_src_o), 32'd1);
        checkOutput("brT.target", pc_target_o, 32'h40);
        checkOutput("brT.flush", 32'(flush_o), 32'd1);
        stepCycle("brT", 1'b0, 1'b0, 1'b0, mkWb(1'b0, 1'b0, 32'h0, 32'h5, 32'h114, 5'd0));
        applyStimulus(5'b00100, 32'h1, 32'h0, 32'h118, 5'd0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("brN.pcSrc", 32'(pc_src_o), 32'd0);
        checkOutput("brN.flush", 32'(flush_o), 32'd0);
        stepCycle("brN", 1'b0, 1'b0, 1'b0, mkWb(1'b0, 1'b0, 32'h0, 32'h1, 32'h118, 5'd0));
        applyStimulus(5'b00000, 32'h0, 32'h0, 32'h11C, 5'd0, 1'b0, 32'h80, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("jmp.pcSrc", 32'(pc_src_o), 32'd1);
        checkOutput("jmp.target", pc_target_o, 32'h80);
        stepCycle("jmp", 1'b0, 1'b0, 1'b0, mkWb(1'b0, 1'b0, 32'h0, 32'h0, 32'h11C, 5'd0));

        // MemRead and MemWrite together behave as a write.
        applyStimulus(5'b11011, 32'h30, 32'h77, 32'h120, 5'd4, 1'b0, '0, 1'b0, 1'b1, 32'h5555);
        #1;
        checkOutput("rw.we", 32'(dmem_we_o), 32'd1);
        stepCycle("rw", 1'b1, 1'b0, 1'b0, mkWb(1'b1, 1'b1, 32'h0, 32'h30, 32'h120, 5'd4));

        // Reset asserted mid-access, then a stray ack after release.
        applyStimulus(5'b11010, 32'h50, 32'h0, 32'h124, 5'd8, 1'b0, '0, 1'b0, 1'b0, 32'h0);
        stepCycle("rstLd", 1'b1, 1'b1, 1'b0, bubble);
        @(negedge clk_i);
        checkOutput("rstWait.req", 32'(dmem_req_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstMid.req", 32'(dmem_req_o), 32'd0);
        checkOutput("rstMid.stall", 32'(stall_o), 32'd0);
        checkOutput("rstMid.we", 32'(dmem_we_o), 32'd0);
        checkOutput("rstMid.addr", dmem_addr_o, 32'd0);
        checkOutput("rstMid.wbRegWrite", 32'(wb_regwrite_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        applyStimulus(5'b00000, 32'h70, 32'h0, 32'h200, 5'd3, 1'b0, '0, 1'b0, 1'b1, 32'h0BAD);
        stepCycle("lateAck", 1'b0, 1'b0, 1'b0, mkWb(1'b0, 1'b0, 32'h0, 32'h70, 32'h200, 5'd3));

        // Long access without ack.
        applyStimulus(5'b11010, 32'h60, 32'h0, 32'h204, 5'd2, 1'b0, '0, 1'b0, 1'b0, 32'h0);
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 5; i++) stepCycle($sformatf("to%0d", i), 1'b1, 1'b1, 1'b0, bubble);
        stepCycle("toHit", 1'b0, 1'b0, 1'b0, bubble);
        checkOutput("toHit.timeout", 32'(timeout_o), 32'd1);
        applyStimulus(5'b00000, 32'h8, 32'h0, 32'h208, 5'd1, 1'b0, '0, 1'b0, 1'b0, 32'h0);
        stepCycle("toAfter", 1'b0, 1'b0, 1'b0, mkWb(1'b0, 1'b0, 32'h0, 32'h8, 32'h208, 5'd1));
        checkOutput("toSticky.timeout", 32'(timeout_o), 32'd1);
`else
        for (int i = 0; i < 8; i++) stepCycle($sformatf("long%0d", i), 1'b1, 1'b1, 1'b0, bubble);
        checkOutput("long.timeout", 32'(timeout_o), 32'd0);
        applyStimulus(5'b11010, 32'h60, 32'h0, 32'h204, 5'd2, 1'b0, '0, 1'b0, 1'b1, 32'hCAFEF00D);
        stepCycle("longAck", 1'b1, 1'b0, 1'b0, mkWb(1'b1, 1'b1, 32'hCAFEF00D, 32'h60, 32'h204, 5'd2));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
